// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I-subset decode with register file, load-use stall, branch flush and registered ID/EX outputs
module id_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            ex_flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [3:0]      ex_alu_ctrl,
    output logic [2:0]      ex_funct3,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_alusrc,
    output logic            ex_memtoreg,
    output logic            ex_branch,
    output logic            ex_illegal
);
    localparam int AW = $clog2(NREG);
    localparam logic [5:0] NR = 6'(NREG);
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111;
    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4, ALU_SLTU = 4'd5, ALU_XOR = 4'd6, ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_PASSB = 4'd10;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu;
        logic [2:0]      f3;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            alusrc;
        logic            memtoreg;
        logic            branch;
        logic            illegal;
    } idex_t;

    logic [XLEN-1:0] rf_q [NREG];
    idex_t           idex_d, idex_q;
    logic [6:0]      opc, f7, sh_f7;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      f3;
    logic [5:0]      shamt;
    logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, rs1_data, rs2_data;
    logic            use1, use2, bad, hz;

    function automatic logic [3:0] f3_alu(input logic [2:0] f);
        case (f)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign opc   = if_inst[6:0];
    assign rd    = if_inst[11:7];
    assign f3    = if_inst[14:12];
    assign rs1   = if_inst[19:15];
    assign rs2   = if_inst[24:20];
    assign f7    = if_inst[31:25];
    assign sh_f7 = (XLEN == 64) ? {if_inst[31:26], 1'b0} : f7;
    assign shamt = (XLEN == 64) ? if_inst[25:20] : {1'b0, if_inst[24:20]};
    assign i_imm = XLEN'($signed(if_inst[31:20]));
    assign s_imm = XLEN'($signed({if_inst[31:25], if_inst[11:7]}));
    assign b_imm = XLEN'($signed({if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0}));
    assign u_imm = XLEN'($signed({if_inst[31:12], 12'b0}));

    assign rs1_data = (rs1 == 5'd0 || {1'b0, rs1} >= NR) ? '0 :
                      (WB_BYPASS != 0 && wb_we && wb_rd == rs1) ? wb_data : rf_q[rs1[AW-1:0]];
    assign rs2_data = (rs2 == 5'd0 || {1'b0, rs2} >= NR) ? '0 :
                      (WB_BYPASS != 0 && wb_we && wb_rd == rs2) ? wb_data : rf_q[rs2[AW-1:0]];

    assign hz = idex_q.valid && idex_q.memread && idex_q.rd != 5'd0 && if_valid &&
                ((use1 && rs1 == idex_q.rd) || (use2 && rs2 == idex_q.rd));
    assign id_ready = ex_flush || !hz;

    // decode the instruction in ID into the next ID/EX contents; illegal or empty slots carry no controls
    always_comb begin
        idex_d = '0;
        use1 = 1'b0;
        use2 = 1'b0;
        bad = 1'b0;
        idex_d.valid = if_valid;
        idex_d.pc = if_pc;
        idex_d.rs1 = rs1;
        idex_d.rs2 = rs2;
        idex_d.rd = rd;
        idex_d.f3 = f3;
        idex_d.rs1_data = rs1_data;
        idex_d.rs2_data = rs2_data;
        case (opc)
            OP_R: begin
                use1 = 1'b1;
                use2 = 1'b1;
                idex_d.regwrite = 1'b1;
                idex_d.alu = (f7 == F7_ALT) ? (f3 == 3'b000 ? ALU_SUB : ALU_SRA) : f3_alu(f3);
                bad = !(f7 == 7'b0 || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_I: begin
                use1 = 1'b1;
                idex_d.regwrite = 1'b1;
                idex_d.alusrc = 1'b1;
                idex_d.alu = (f3 == 3'b101 && sh_f7 == F7_ALT) ? ALU_SRA : f3_alu(f3);
                idex_d.imm = (f3 == 3'b001 || f3 == 3'b101) ? XLEN'(shamt) : i_imm;
                bad = (f3 == 3'b001 && sh_f7 != 7'b0) ||
                      (f3 == 3'b101 && sh_f7 != 7'b0 && sh_f7 != F7_ALT);
            end
            OP_LD: begin
                use1 = 1'b1;
                idex_d.regwrite = 1'b1;
                idex_d.memread = 1'b1;
                idex_d.memtoreg = 1'b1;
                idex_d.alusrc = 1'b1;
                idex_d.imm = i_imm;
            end
            OP_ST: begin
                use1 = 1'b1;
                use2 = 1'b1;
                idex_d.memwrite = 1'b1;
                idex_d.alusrc = 1'b1;
                idex_d.imm = s_imm;
            end
            OP_BR: begin
                use1 = 1'b1;
                use2 = 1'b1;
                idex_d.branch = 1'b1;
                idex_d.alu = ALU_SUB;
                idex_d.imm = b_imm;
                bad = f3[1];
            end
            OP_LUI: begin
                idex_d.regwrite = 1'b1;
                idex_d.alusrc = 1'b1;
                idex_d.alu = ALU_PASSB;
                idex_d.imm = u_imm;
            end
            default: bad = 1'b1;
        endcase
        idex_d.illegal = if_valid && (bad || (use1 && {1'b0, rs1} >= NR) ||
                         (use2 && {1'b0, rs2} >= NR) || (idex_d.regwrite && {1'b0, rd} >= NR));
        if (idex_d.illegal || !if_valid) begin
            {idex_d.regwrite, idex_d.memread, idex_d.memwrite} = 3'b000;
            {idex_d.alusrc, idex_d.memtoreg, idex_d.branch} = 3'b000;
            idex_d.alu = ALU_ADD;
        end
    end

    // register file: WB writes land at the edge; x0 and out-of-range indices are never stored
    always_ff @(posedge clk) begin
        if (rst)
            rf_q <= '{default: '0};
        else if (wb_we && wb_rd != 5'd0 && {1'b0, wb_rd} < NR)
            rf_q[wb_rd[AW-1:0]] <= wb_data;
    end

    // ID/EX register: reset, flush and load-use bubble all leave an empty slot
    always_ff @(posedge clk) begin
        idex_q <= (rst || ex_flush || hz) ? '0 : idex_d;
    end

    assign ex_valid    = idex_q.valid;
    assign ex_pc       = idex_q.pc;
    assign ex_rs1      = idex_q.rs1;
    assign ex_rs2      = idex_q.rs2;
    assign ex_rd       = idex_q.rd;
    assign ex_rs1_data = idex_q.rs1_data;
    assign ex_rs2_data = idex_q.rs2_data;
    assign ex_imm      = idex_q.imm;
    assign ex_alu_ctrl = idex_q.alu;
    assign ex_funct3   = idex_q.f3;
    assign ex_regwrite = idex_q.regwrite;
    assign ex_memread  = idex_q.memread;
    assign ex_memwrite = idex_q.memwrite;
    assign ex_alusrc   = idex_q.alusrc;
    assign ex_memtoreg = idex_q.memtoreg;
    assign ex_branch   = idex_q.branch;
    assign ex_illegal  = idex_q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: vector table with scoreboard against a default instance and an XLEN=64/NREG=16/no-bypass instance
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst, if_valid, ex_flush, wb_we;
    logic [31:0] if_inst, if_pc, wb_data;
    logic [4:0]  wb_rd;

    logic        id_ready, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc, ex_memtoreg, ex_branch, ex_illegal;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_ctrl;
    logic [2:0]  ex_funct3;

    logic        id_ready2, ex_valid2, ex_regwrite2, ex_memread2, ex_memwrite2, ex_alusrc2, ex_memtoreg2, ex_branch2, ex_illegal2;
    logic [63:0] ex_pc2, ex_rs1_data2, ex_rs2_data2, ex_imm2;
    logic [4:0]  ex_rs12, ex_rs22, ex_rd2;
    logic [3:0]  ex_alu_ctrl2;
    logic [2:0]  ex_funct32;

    int checks = 0, errors = 0, cur = -1;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready), .ex_flush(ex_flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_funct3(ex_funct3), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    id_stage_pipe #(.XLEN(64), .NREG(16), .WB_BYPASS(0)) dut2 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc({32'b0, if_pc}),
        .id_ready(id_ready2), .ex_flush(ex_flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data({32'b0, wb_data}),
        .ex_valid(ex_valid2), .ex_pc(ex_pc2), .ex_rs1(ex_rs12), .ex_rs2(ex_rs22), .ex_rd(ex_rd2),
        .ex_rs1_data(ex_rs1_data2), .ex_rs2_data(ex_rs2_data2), .ex_imm(ex_imm2), .ex_alu_ctrl(ex_alu_ctrl2),
        .ex_funct3(ex_funct32), .ex_regwrite(ex_regwrite2), .ex_memread(ex_memread2), .ex_memwrite(ex_memwrite2),
        .ex_alusrc(ex_alusrc2), .ex_memtoreg(ex_memtoreg2), .ex_branch(ex_branch2), .ex_illegal(ex_illegal2)
    );

    typedef struct {
        logic        valid, flush, we;
        logic [31:0] inst, pc, wdata;
        logic [4:0]  wrd;
        logic        e_ready, e_valid;
        logic [5:0]  e_ctrl;
        int          lvl;
        logic [4:0]  e_rs1, e_rd;
        logic [31:0] e_d1, e_imm;
        logic [2:0]  e_f3;
        logic        e_ill;
        logic [3:0]  e_alu;
        int          c2;
        logic [63:0] e2_d1, e2_imm;
        logic        e2_ill;
    } vec_t;

    vec_t tv[$];
    vec_t sb[$];

    localparam logic [5:0] C_R = 6'b100000, C_I = 6'b100100, C_LD = 6'b110110;
    localparam logic [5:0] C_ST = 6'b001100, C_BR = 6'b000001, C_0 = 6'b000000;

    function automatic logic [31:0] ienc(input logic [11:0] imm, input logic [4:0] s1, input logic [2:0] f, input logic [4:0] d, input logic [6:0] op);
        return {imm, s1, f, d, op};
    endfunction
    function automatic logic [31:0] renc(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1, input logic [2:0] f, input logic [4:0] d);
        return {f7, s2, s1, f, d, 7'b0110011};
    endfunction
    function automatic logic [31:0] senc(input logic [11:0] imm, input logic [4:0] s2, input logic [4:0] s1, input logic [2:0] f);
        return {imm[11:5], s2, s1, f, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] benc(input logic [12:0] imm, input logic [4:0] s2, input logic [4:0] s1, input logic [2:0] f);
        return {imm[12], imm[10:5], s2, s1, f, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic vec_t mk(input logic valid, input logic [31:0] inst, input logic flush, input logic we,
                                input logic [4:0] wrd, input logic [31:0] wdata, input logic e_ready, input logic e_valid,
                                input logic [5:0] e_ctrl, input int lvl, input logic [4:0] e_rs1, input logic [4:0] e_rd,
                                input logic [31:0] e_d1, input logic [2:0] e_f3, input logic e_ill,
                                input logic [31:0] e_imm, input logic [3:0] e_alu);
        vec_t v;
        v.valid = valid; v.inst = inst; v.flush = flush; v.we = we; v.wrd = wrd; v.wdata = wdata; v.pc = '0;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_ctrl = e_ctrl; v.lvl = lvl; v.e_rs1 = e_rs1; v.e_rd = e_rd;
        v.e_d1 = e_d1; v.e_f3 = e_f3; v.e_ill = e_ill; v.e_imm = e_imm; v.e_alu = e_alu;
        v.c2 = 0; v.e2_d1 = '0; v.e2_imm = '0; v.e2_ill = 1'b0;
        return v;
    endfunction

    function automatic vec_t x2(input vec_t v, input int c, input logic [63:0] d1, input logic ill, input logic [63:0] imm);
        vec_t r = v;
        r.c2 = c; r.e2_d1 = d1; r.e2_ill = ill; r.e2_imm = imm;
        return r;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got %h, expected %h", n, cur, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        logic [31:0] addi_x6_x5 = ienc(12'd1, 5'd5, 3'b000, 5'd6, 7'b0010011);
        logic [31:0] lw_x3 = ienc(12'd8, 5'd1, 3'b010, 5'd3, 7'b0000011);
        logic [31:0] add_x4_x3 = renc(7'b0, 5'd2, 5'd3, 3'b000, 5'd4);
        logic [31:0] add_x8_x7 = renc(7'b0, 5'd0, 5'd7, 3'b000, 5'd8);
        logic [31:0] add_x9_x0 = renc(7'b0, 5'd0, 5'd0, 3'b000, 5'd9);
        tv.push_back(mk(1, addi_x6_x5, 0, 0, 0, 0,                 1, 1, C_I, 3, 5, 6, 32'h0, 0, 0, 32'd1, 0));
        tv.push_back(mk(0, 32'h0, 0, 1, 5, 32'h1234,               1, 0, C_0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(x2(mk(1, addi_x6_x5, 0, 0, 0, 0,              1, 1, C_I, 3, 5, 6, 32'h1234, 0, 0, 32'd1, 0), 2, 64'h1234, 0, 64'd1));
        tv.push_back(x2(mk(1, add_x8_x7, 0, 1, 7, 32'hCAFE,        1, 1, C_R, 2, 7, 8, 32'hCAFE, 0, 0, 0, 0), 1, 64'h0, 0, 0));
        tv.push_back(x2(mk(1, add_x8_x7, 0, 0, 0, 0,               1, 1, C_R, 2, 7, 8, 32'hCAFE, 0, 0, 0, 0), 1, 64'hCAFE, 0, 0));
        tv.push_back(x2(mk(1, add_x9_x0, 0, 1, 0, 32'hFFFF,        1, 1, C_R, 2, 0, 9, 32'h0, 0, 0, 0, 0), 1, 64'h0, 0, 0));
        tv.push_back(x2(mk(1, add_x9_x0, 0, 0, 0, 0,               1, 1, C_R, 2, 0, 9, 32'h0, 0, 0, 0, 0), 1, 64'h0, 0, 0));
        tv.push_back(mk(1, lw_x3, 0, 0, 0, 0,                      1, 1, C_LD, 3, 1, 3, 32'h0, 2, 0, 32'd8, 0));
        tv.push_back(mk(1, add_x4_x3, 0, 0, 0, 0,                  0, 0, C_0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, add_x4_x3, 0, 0, 0, 0,                  1, 1, C_R, 2, 3, 4, 32'h0, 0, 0, 0, 0));
        tv.push_back(mk(1, lw_x3, 0, 0, 0, 0,                      1, 1, C_LD, 3, 1, 3, 32'h0, 2, 0, 32'd8, 0));
        tv.push_back(x2(mk(1, {20'h80000, 5'd3, 7'b0110111}, 0, 0, 0, 0, 1, 1, C_I, 3, 0, 3, 32'h0, 0, 0, 32'h80000000, 10), 2, 64'h0, 0, 64'hFFFFFFFF80000000));
        tv.push_back(mk(1, lw_x3, 0, 1, 1, 32'h100,                1, 1, C_LD, 3, 1, 3, 32'h100, 2, 0, 32'd8, 0));
        tv.push_back(mk(1, add_x4_x3, 1, 0, 0, 0,                  1, 0, C_0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, senc(12'hFFC, 5'd2, 5'd1, 3'b010), 0, 0, 0, 0, 1, 1, C_ST, 3, 1, 28, 32'h100, 2, 0, 32'hFFFFFFFC, 0));
        tv.push_back(mk(1, benc(13'h1FF8, 5'd2, 5'd1, 3'b000), 0, 0, 0, 0, 1, 1, C_BR, 3, 1, 25, 32'h100, 0, 0, 32'hFFFFFFF8, 1));
        tv.push_back(x2(mk(1, ienc({7'b0100000, 5'd3}, 5'd2, 3'b101, 5'd1, 7'b0010011), 0, 0, 0, 0, 1, 1, C_I, 3, 2, 1, 32'h0, 5, 0, 32'd3, 9), 2, 64'h0, 0, 64'd3));
        tv.push_back(x2(mk(1, 32'h0000007F, 0, 0, 0, 0,            1, 1, C_0, 3, 0, 0, 32'h0, 0, 1, 32'h0, 0), 2, 64'h0, 1, 64'h0));
        tv.push_back(mk(1, renc(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd5), 0, 0, 0, 0, 1, 1, C_0, 1, 1, 5, 32'h100, 0, 1, 0, 0));
        tv.push_back(mk(1, benc(13'd8, 5'd2, 5'd1, 3'b010), 0, 0, 0, 0, 1, 1, C_0, 1, 1, 8, 32'h100, 2, 1, 0, 0));
        tv.push_back(x2(mk(1, renc(7'b0, 5'd2, 5'd1, 3'b000, 5'd17), 0, 0, 0, 0, 1, 1, C_R, 2, 1, 17, 32'h100, 0, 0, 0, 0), 1, 64'h100, 1, 0));
        tv.push_back(mk(0, 32'h0, 0, 1, 4, 32'h44,                 1, 0, C_0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 32'h0, 0, 1, 20, 32'h2020,              1, 0, C_0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(x2(mk(1, renc(7'b0, 5'd0, 5'd4, 3'b000, 5'd9), 0, 0, 0, 0, 1, 1, C_R, 2, 4, 9, 32'h44, 0, 0, 0, 0), 1, 64'h44, 0, 0));
        tv.push_back(mk(1, renc(7'b0, 5'd0, 5'd20, 3'b000, 5'd9), 0, 0, 0, 0, 1, 1, C_R, 2, 20, 9, 32'h2020, 0, 0, 0, 0));
        tv.push_back(mk(1, ienc(12'd0, 5'd1, 3'b010, 5'd2, 7'b0000011), 0, 0, 0, 0, 1, 1, C_LD, 3, 1, 2, 32'h100, 2, 0, 32'h0, 0));
        tv.push_back(mk(1, renc(7'b0, 5'd2, 5'd1, 3'b000, 5'd4), 0, 0, 0, 0, 0, 0, C_0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, renc(7'b0, 5'd2, 5'd1, 3'b000, 5'd4), 0, 0, 0, 0, 1, 1, C_R, 2, 1, 4, 32'h100, 0, 0, 0, 0));
        tv.push_back(mk(1, ienc(12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011), 0, 0, 0, 0, 1, 1, C_LD, 3, 1, 0, 32'h100, 2, 0, 32'h0, 0));
        tv.push_back(mk(1, renc(7'b0, 5'd0, 5'd0, 3'b000, 5'd4), 0, 0, 0, 0, 1, 1, C_R, 2, 0, 4, 32'h0, 0, 0, 0, 0));
        tv.push_back(mk(1, renc(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd10), 0, 0, 0, 0, 1, 1, C_R, 2, 1, 10, 32'h100, 0, 0, 0, 1));
        tv.push_back(mk(1, ienc(12'hFFF, 5'd1, 3'b100, 5'd11, 7'b0010011), 0, 0, 0, 0, 1, 1, C_I, 3, 1, 11, 32'h100, 4, 0, 32'hFFFFFFFF, 6));
        tv.push_back(x2(mk(1, ienc({7'b0, 5'd31}, 5'd1, 3'b001, 5'd12, 7'b0010011), 0, 0, 0, 0, 1, 1, C_I, 3, 1, 12, 32'h100, 1, 0, 32'd31, 7), 2, 64'h100, 0, 64'd31));
        tv.push_back(x2(mk(1, ienc({7'b0000001, 5'd1}, 5'd1, 3'b001, 5'd12, 7'b0010011), 0, 0, 0, 0, 1, 1, C_0, 1, 1, 12, 32'h100, 1, 1, 0, 0), 2, 64'h100, 0, 64'd33));

        rst = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0; ex_flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", ex_valid, 0);
        chk("reset_ctrl", {ex_regwrite, ex_memread, ex_memwrite, ex_alusrc, ex_memtoreg, ex_branch}, 0);
        chk("reset_pc", ex_pc, 0);
        chk("reset_ready", id_ready, 1);
        chk("reset_valid2", ex_valid2, 0);
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            cur = i;
            rst = 1'b0;
            e = tv[i];
            e.pc = 32'h1000 + 32'(4 * i);
            if_valid = e.valid; if_inst = e.inst; if_pc = e.pc; ex_flush = e.flush;
            wb_we = e.we; wb_rd = e.wrd; wb_data = e.wdata;
            #1;
            chk("id_ready", id_ready, e.e_ready);
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("ex_valid", ex_valid, e.e_valid);
            chk("ctrl", {ex_regwrite, ex_memread, ex_memwrite, ex_alusrc, ex_memtoreg, ex_branch}, e.e_ctrl);
            if (e.lvl >= 1) begin
                chk("ex_pc", ex_pc, e.pc);
                chk("ex_rs1", ex_rs1, e.e_rs1);
                chk("ex_rd", ex_rd, e.e_rd);
                chk("ex_rs1_data", ex_rs1_data, e.e_d1);
                chk("ex_funct3", ex_funct3, e.e_f3);
                chk("ex_illegal", ex_illegal, e.e_ill);
            end
            if (e.lvl >= 2) chk("ex_alu_ctrl", ex_alu_ctrl, e.e_alu);
            if (e.lvl >= 3) chk("ex_imm", ex_imm, e.e_imm);
            if (e.c2 >= 1) begin
                chk("x64_rs1_data", ex_rs1_data2, e.e2_d1);
                chk("x64_illegal", ex_illegal2, e.e2_ill);
            end
            if (e.c2 >= 2) chk("x64_imm", ex_imm2, e.e2_imm);
        end
        cur = -1;
        @(negedge clk);
        rst = 1'b1; if_valid = 1'b1; if_inst = addi_x6_x5; ex_flush = 1'b0; wb_we = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid", ex_valid, 0);
        chk("midrst_ctrl", {ex_regwrite, ex_memread, ex_memwrite, ex_alusrc, ex_memtoreg, ex_branch}, 0);
        chk("midrst_valid2", ex_valid2, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_valid", ex_valid, 1);
        chk("postrst_x5", ex_rs1_data, 0);
        chk("postrst_x5_2", ex_rs1_data2, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised successor to the single-cycle decode stage.
- Decodes an extended RV32I subset and reads a parametrised register file.
- Registered ID/EX pipeline register as output.
- Load-use hazard detection with stall/bubble insertion, branch flush, and a dedicated WB write port with write-through bypass.
- Sits between the IF/ID register and the EX stage of the 5-stage core.

Parameters:
XLEN, 32, datapath width of registers, immediates and PC (32 or 64)
NREG, 32, architectural register count (32 = RV32I, 16 = RV32E)
WB_BYPASS, 1, 1 = same-cycle WB write forwarded to read ports; 0 = read returns old value

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
if_valid  in  1  if_inst/if_pc carry a real instruction
if_inst  in  32  instruction word
if_pc  in  XLEN  PC of if_inst
id_ready  out  1  combinational; 0 = IF must hold inst/pc this cycle
ex_flush  in  1  taken branch in EX; kill instruction in ID
wb_we  in  1  WB register write enable
wb_rd  in  5  WB destination index
wb_data  in  XLEN  WB write data
ex_valid  out  1  ID/EX register holds a live instruction
ex_pc  out  XLEN  registered PC
ex_rs1, ex_rs2, ex_rd  out  5 each  registered register fields
ex_rs1_data, ex_rs2_data  out  XLEN each  registered operand data
ex_imm  out  XLEN  selected immediate, sign-extended to XLEN
ex_alu_ctrl  out  4  ALU operation
ex_funct3  out  3  raw funct3, used for branch condition and load/store size
ex_regwrite, ex_memread, ex_memwrite, ex_alusrc, ex_memtoreg, ex_branch  out  1 each  control
ex_illegal  out  1  unsupported opcode, or a register index >= NREG

Behaviour:
- Reset (rst=1 at edge):
  - All ID/EX outputs clear to 0; ex_valid=0.
  - All NREG registers clear to 0.
  - id_ready remains combinational.
- Register file:
  - Written on a clock edge when wb_we=1, wb_rd!=0 and wb_rd<NREG.
  - Write is independent of the instruction being decoded.
  - Reads are combinational; x0 always reads 0.
  - WB_BYPASS=1: if wb_we && wb_rd==rsN && rsN!=0, read data = wb_data.
- ALU encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLTU, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 PASSB.
- Decode by opcode:
  - 0110011 R-type: add/sub/and/or/xor/slt/sltu/sll/srl/sra; any other funct7/funct3 combination is illegal.
  - 0010011 I-type: addi/andi/ori/xori/slti/sltiu/slli/srli/srai.
    - Shifts use imm[4:0] (XLEN=32) or imm[5:0] (XLEN=64).
    - funct7 0000000 selects SLL/SRL; 0100000 selects SRA.
  - 0000011 load: memread, memtoreg, alusrc, ADD, I-imm.
  - 0100011 store: memwrite, alusrc, ADD, S-imm.
  - 1100011 branch: branch=1, SUB, B-imm with bit0=0; funct3 000/001/100/101 legal, others illegal.
  - 0110111 lui: regwrite, alusrc, PASSB, imm = inst[31:12]<<12, sign-extended.
  - Any other opcode: illegal. All controls 0, ex_illegal=1, ex_valid follows if_valid.
- Source-use flags:
  - rs1 is used by R, I, load, store and branch.
  - rs2 is used by R, store and branch.
  - lui uses neither.
- Load-use hazard:
  - hz = ex_valid && ex_memread && ex_rd!=0 && if_valid && ((use_rs1 && rs1==ex_rd) || (use_rs2 && rs2==ex_rd)).
- Next-state per edge, priority order:
  1. rst: clear everything.
  2. ex_flush: ex_valid<=0, other fields don't-care (0); id_ready=1, and IF discards.
  3. hz: bubble, ex_valid<=0 and all controls<=0; id_ready=0 and IF holds.
  4. else: load decode, ex_valid<=if_valid; id_ready=1.
- Any instruction with ex_valid=0 has all six control bits 0.
- Hazard stall lasts exactly 1 cycle. After the bubble, ex_memread=0, so hz deasserts.
- Latency: one cycle from IF/ID to ID/EX.

Test Plan:
1. Reset: after rst, ex_valid=0, all controls 0, x5 reads 0. Then WB writes x5=0x1234 and `addi x6,x5,1` is decoded: ex_rs1_data=0x1234, ex_imm=1, ex_alu_ctrl=0, ex_regwrite=1.
2. Bypass: wb_we=1, wb_rd=7, wb_data=0xCAFE in the same cycle as `add x8,x7,x0`. WB_BYPASS=1 gives ex_rs1_data=0xCAFE; WB_BYPASS=0 gives the old value 0. A write to x0 leaves x0=0.
3. Load-use: `lw x3,8(x1)` then `add x4,x3,x2`.
   - Cycle 2: id_ready=0, and ex_valid=0 next.
   - Cycle 3: add is issued with ex_rs1=3.
   - `lw x3` followed by `lui x3,...` causes no stall.
4. Flush over hazard: ex_flush=1 while hz=1 gives ex_valid=0 and id_ready=1 next cycle.
5. Immediates:
   - `sw x2,-4(x1)`: ex_imm=0xFFFFFFFC.
   - `beq` with offset -8: ex_imm=0xFFFFFFF8, ex_branch=1, ex_funct3=0.
   - `lui x1,0x80000` with XLEN=64: ex_imm=0xFFFFFFFF80000000.
   - `srai x1,x2,3`: alu_ctrl=9, imm[4:0]=3.
6. Illegal: opcode 1111111 gives ex_illegal=1 and controls 0. With NREG=16, `add x17,x1,x2` gives ex_illegal=1, and a WB write to x20 is ignored.
